// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: turns symbolic MIPS instruction fields into 32-bit
// instruction words and writes them into imem at an auto-incrementing
// address. The bring-up harness uses it to load a program before the core
// is released from reset.
//
// Optional feature macro: ENC_BRANCH_REL_EN
//   When it is defined, BEQ/BNE take imm as an absolute word address. The
//   block then writes offset = imm - (wr_ptr + 1), truncated to 16 bits.
//   When it is undefined, imm is passed through unchanged for every I-type op.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   start           synchronous pulse: clears wr_ptr, instr_count and full
//   in_valid/ready  handshake for the instruction fields
//   op_sel          0=ADD 1=ADDI 2=LW 3=SW 4=BEQ 5=BNE 6=J 7=reserved
//   rs, rt, rd      register fields (rd is used by ADD only)
//   imm, target     immediate/branch offset, and J word target
//   imem_we/addr/wdata  registered imem write port
//   instr_count     instructions written since the last start or reset
//   full            instr_count == DEPTH
//   err_illegal     one-cycle pulse when a reserved op_sel is accepted
//   busy            high while the write cycle is in progress
module instr_encoder_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   instr_count,
    output logic              full,
    output logic              err_illegal,
    output logic              busy
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_BNE  = 3'd5;
    localparam logic [2:0] OP_J    = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;

    logic [15:0]         branch_imm;
    logic [31:0]         enc_word;

`ifdef ENC_BRANCH_REL_EN
    logic [16:0]         rel_off;

    // Absolute branch target becomes an offset from the next instruction slot.
    always_comb begin
        rel_off    = 17'(imm) - (17'(wr_ptr_q) + 17'd1);
        branch_imm = rel_off[15:0];
    end
`else
    assign branch_imm = imm;
`endif

    // Encode the fields of each op class. Fields an op does not use stay out of the word.
    always_comb begin
        enc_word = '0;
        case (op_sel)
            OP_ADD:  enc_word = {OPC_RTYPE, rs, rt, rd, 5'b00000, FUNCT_ADD};
            OP_ADDI: enc_word = {OPC_ADDI, rs, rt, imm};
            OP_LW:   enc_word = {OPC_LW, rs, rt, imm};
            OP_SW:   enc_word = {OPC_SW, rs, rt, imm};
            OP_BEQ:  enc_word = {OPC_BEQ, rs, rt, branch_imm};
            OP_BNE:  enc_word = {OPC_BNE, rs, rt, branch_imm};
            OP_J:    enc_word = {OPC_J, target};
            default: enc_word = '0;
        endcase
    end

    // start blocks acceptance so that it wins over a concurrent in_valid.
    assign in_ready = (state_q == S_IDLE) && !full_q && !start;

    // Next-state logic and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wr_ptr_d = '0;
                    count_d  = '0;
                    full_d   = 1'b0;
                end else if (in_valid && in_ready) begin
                    if (op_sel == OP_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = wr_ptr_q;
                        wdata_d = enc_word;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                // The write still completes; start only redirects the bookkeeping.
                if (start) begin
                    wr_ptr_d = '0;
                    count_d  = '0;
                    full_d   = 1'b0;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                    full_d   = (count_q + CNT_W'(1)) == CNT_W'(DEPTH);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign instr_count = count_q;
    assign full        = full_q;
    assign err_illegal = err_q;
    assign busy        = (state_q == S_WRITE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader with a small imem (ADDR_W=2, DEPTH=4), so
// that full and the pointer wrap are reached quickly.
module tb_instr_encoder_loader;

    localparam int unsigned AW = 2;
    localparam int unsigned DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    op_sel = '0;
    logic [4:0]    rs = '0;
    logic [4:0]    rt = '0;
    logic [4:0]    rd = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   instr_count;
    logic          full;
    logic          err_illegal;
    logic          busy;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .instr_count(instr_count), .full(full),
        .err_illegal(err_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoding, built arithmetically from the instruction formats.
    function automatic logic [31:0] itype(input int unsigned opc, input int unsigned a_rs,
                                          input int unsigned a_rt, input int unsigned a_imm);
        return (32'(opc) << 26) | (32'(a_rs) << 21) | (32'(a_rt) << 16) | (32'(a_imm) & 32'hFFFF);
    endfunction

    function automatic logic [31:0] model_enc(input int unsigned op, input int unsigned a_rs,
                                              input int unsigned a_rt, input int unsigned a_rd,
                                              input int unsigned a_imm, input int unsigned a_tgt,
                                              input int unsigned ptr);
        int unsigned bimm;
`ifdef ENC_BRANCH_REL_EN
        bimm = (a_imm - (ptr + 1)) & 32'hFFFF;
`else
        bimm = a_imm + (ptr * 0);
`endif
        case (op)
            0: return (32'(a_rs) << 21) | (32'(a_rt) << 16) | (32'(a_rd) << 11) | 32'd32;
            1: return itype(8, a_rs, a_rt, a_imm);
            2: return itype(35, a_rs, a_rt, a_imm);
            3: return itype(43, a_rs, a_rt, a_imm);
            4: return itype(4, a_rs, a_rt, bimm);
            5: return itype(5, a_rs, a_rt, bimm);
            6: return (32'd2 << 26) | (32'(a_tgt) & 32'h03FF_FFFF);
            default: return 32'd0;
        endcase
    endfunction

    // Transaction-level model: count of words written since start/reset, plus
    // whether a write is in flight this cycle and what it carries.
    int          m_count = 0;
    bit          m_busy = 1'b0;
    bit          m_err = 1'b0;
    bit          m_acc;
    int          m_addr = 0;
    logic [31:0] m_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0;
            m_busy  = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_acc = !m_busy && in_valid && (m_count != DP) && !start;
            m_err = m_acc && (op_sel == 3'd7);
            if (m_busy) m_count = start ? 0 : m_count + 1;
            else if (start) m_count = 0;
            if (m_acc && op_sel != 3'd7) begin
                m_addr = m_count % (1 << AW);
                m_data = model_enc(op_sel, rs, rt, rd, imm, target, m_addr);
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_we", 32'(imem_we), 32'(m_busy));
            if (m_busy) begin
                chk("cyc_addr", 32'(imem_addr), 32'(m_addr));
                chk("cyc_wdata", imem_wdata, m_data);
            end
            chk("cyc_count", 32'(instr_count), 32'(m_count));
            chk("cyc_full", 32'(full), 32'(m_count == DP));
            chk("cyc_err", 32'(err_illegal), 32'(m_err));
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_ready", 32'(in_ready), 32'(!m_busy && m_count != DP && !start));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_fields(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
        op_sel = o; rs = s; rt = t; rd = d; imm = i; target = g;
    endtask

    // Present fields and hold until accepted; returns just after the handshake edge.
    task automatic send(input logic [2:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
        bit ok;
        ok = 1'b0;
        set_fields(o, s, t, d, i, g);
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("handshake", 32'(ok), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input string nm, input int unsigned a, input logic [31:0] w);
        chk({nm, "_we"}, 32'(imem_we), 32'd1);
        chk({nm, "_addr"}, 32'(imem_addr), 32'(a));
        chk({nm, "_wdata"}, imem_wdata, w);
        chk({nm, "_ready"}, 32'(in_ready), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic expect_reset(input string nm);
        chk({nm, "_ready"}, 32'(in_ready), 32'd1);
        chk({nm, "_we"}, 32'(imem_we), 32'd0);
        chk({nm, "_addr"}, 32'(imem_addr), 32'd0);
        chk({nm, "_wdata"}, imem_wdata, 32'd0);
        chk({nm, "_count"}, 32'(instr_count), 32'd0);
        chk({nm, "_full"}, 32'(full), 32'd0);
        chk({nm, "_err"}, 32'(err_illegal), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] beq_exp;
        logic [31:0] bne_exp;
        logic [15:0] beq_imm;
`ifdef ENC_BRANCH_REL_EN
        beq_imm = 16'h0000;
        beq_exp = 32'h1022FFFD;
        bne_exp = 32'h14641230;
`else
        beq_imm = 16'hFFFE;
        beq_exp = 32'h1022FFFE;
        bne_exp = 32'h14641234;
`endif
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        expect_reset("rst");
        chk_en = 1'b1;

        // Single ADD; unused imm/target carry junk that must not leak.
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h3FFFFFF);
        expect_write("add0", 0, 32'h00221820);
        tick();
        chk("add0_count", 32'(instr_count), 32'd1);
        chk("add0_we_low", 32'(imem_we), 32'd0);

        // Back-to-back I-type loads/stores.
        pulse_start();
        send(3'd1, 5'd0, 5'd8, 5'd31, 16'h0005, 26'h155);
        expect_write("addi", 0, 32'h20080005);
        send(3'd2, 5'd8, 5'd9, 5'd0, 16'h0004, 26'h0);
        expect_write("lw", 1, 32'h8D090004);
        send(3'd3, 5'd8, 5'd9, 5'd0, 16'h0004, 26'h0);
        expect_write("sw", 2, 32'h AD090004);
        tick();
        chk("ldst_count", 32'(instr_count), 32'd3);

        // J, ADD, reserved op, then branches filling the memory.
        pulse_start();
        send(3'd6, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010);
        expect_write("j", 0, 32'h08000010);
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        expect_write("add1", 1, 32'h00221820);
        tick();
        send(3'd7, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        chk("ill_err", 32'(err_illegal), 32'd1);
        chk("ill_we", 32'(imem_we), 32'd0);
        tick();
        chk("ill_err_clr", 32'(err_illegal), 32'd0);
        chk("ill_count", 32'(instr_count), 32'd2);
        send(3'd4, 5'd1, 5'd2, 5'd9, beq_imm, 26'h3FFFFFF);
        expect_write("beq", 2, beq_exp);
        send(3'd5, 5'd3, 5'd4, 5'd31, 16'h1234, 26'h3FFFFFF);
        expect_write("bne", 3, bne_exp);
        tick();
        chk("full_set", 32'(full), 32'd1);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(instr_count), 32'd4);

        // Requests while full are dropped silently.
        set_fields(3'd0, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0);
        in_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("full_nowrite", 32'(imem_we), 32'd0);
            chk("full_noerr", 32'(err_illegal), 32'd0);
        end
        in_valid = 1'b0;
        pulse_start();
        chk("restart_full", 32'(full), 32'd0);
        chk("restart_count", 32'(instr_count), 32'd0);
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        expect_write("restart", 0, 32'h00221820);

        // start during a write: the write completes, the count is cleared.
        tick();
        send(3'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        expect_write("sw_wr", 1, 32'h00853020);
        pulse_start();
        chk("sw_count", 32'(instr_count), 32'd0);
        send(3'd1, 5'd2, 5'd3, 5'd0, 16'h8000, 26'h0);
        expect_write("after_sw", 0, 32'h20438000);

        // Reset during a write drops it.
        tick();
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        expect_write("pre_rst", 1, 32'h00221820);
        rst_n = 1'b0;
        #1;
        expect_reset("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        expect_write("post_rst", 0, 32'h00221820);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the MIPS opcode/control decoder. It takes symbolic instruction fields (op class, registers, immediate, jump target) over a valid/ready handshake.
- It builds the 32-bit MIPS instruction word and writes it into instruction memory at an auto-incrementing address.
- Used by the bring-up/emulation harness to load programs into imem before the core is released from reset.

Parameters:
- ADDR_W, 8, imem word-address width
- DEPTH, 256, max instructions loadable; legal range 1..2^ADDR_W

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assertion, active-low
- start  in  1  synchronous pulse: clear write pointer, count, full
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept fields
- op_sel  in  3  0=ADD 1=ADDI 2=LW 3=SW 4=BEQ 5=BNE 6=J 7=reserved
- rs  in  5  source register
- rt  in  5  target register
- rd  in  5  destination register (ADD only)
- imm  in  16  immediate / branch offset
- target  in  26  jump word target (J only)
- imem_we  out  1  imem write strobe, registered
- imem_addr  out  ADDR_W  imem write address, registered
- imem_wdata  out  32  encoded instruction, registered
- instr_count  out  ADDR_W+1  instructions written since start/reset
- full  out  1  instr_count == DEPTH
- err_illegal  out  1  one-cycle pulse on reserved op_sel
- busy  out  1  high in WRITE state

Behaviour:
- Reset values:
  - in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, instr_count=0, full=0, err_illegal=0, busy=0.
  - FSM=IDLE, wr_ptr=0.
- FSM states: IDLE, WRITE.
- IDLE:
  - in_ready = !full && !start.
  - A handshake is in_valid && in_ready. On a legal op it registers the encoded word and goes to WRITE.
  - On op_sel=7: err_illegal=1 next cycle, FSM stays IDLE, no write, count unchanged.
- WRITE (exactly 1 cycle):
  - imem_we=1, imem_addr=wr_ptr, imem_wdata=encoded word, in_ready=0, busy=1.
  - At end of cycle wr_ptr++ and instr_count++; return to IDLE.
- Latency and throughput:
  - imem_we is asserted in the cycle after the handshake.
  - Throughput is 1 instruction per 2 cycles.
- Encoding, with fields packed MSB first:
  - ADD (R-type): 000000 | rs | rt | rd | 00000 | 100000.
  - ADDI, LW, SW, BEQ and BNE (I-type): opcode | rs | rt | imm. Opcodes are 001000, 100011, 101011, 000100 and 000101 respectively.
  - J: 000010 | target.
  - Fields not used by an op class are ignored and never leak into the word.
- Full:
  - full asserts the cycle instr_count reaches DEPTH, which forces in_ready=0.
  - in_valid while full is ignored, with no error pulse.
- wr_ptr wrap: wr_ptr wraps modulo 2^ADDR_W. It only matters when DEPTH = 2^ADDR_W, and full prevents a further write.
- start:
  - Clears wr_ptr, instr_count and full next cycle.
  - Has priority over in_valid in IDLE.
  - If asserted during WRITE, the write in progress completes (imem_we stays 1) but wr_ptr/instr_count are cleared instead of incremented.
- Reset mid-operation: asynchronous clear of all outputs to reset values; a write in flight is dropped.

Optional Feature:
- Macro: ENC_BRANCH_REL_EN.
- Defined:
  - For BEQ/BNE, imm is an absolute word address.
  - The encoder writes offset = imm − (wr_ptr + 1), computed in 17 bits and truncated to 16.
  - Other ops are unchanged.
- Undefined: imm is passed through verbatim for all I-type ops.

Test Plan:
- ADD rs=1 rt=2 rd=3 after reset -> one cycle later imem_we=1, addr=0, wdata=0x00221820; instr_count=1.
- ADDI rt=8 rs=0 imm=5, then LW rt=9 rs=8 imm=4, then SW rt=9 rs=8 imm=4 back-to-back -> addr 0/1/2, wdata 0x20080005 / 0x8D090004 / 0xAD090004; in_ready low in each WRITE cycle.
- BEQ rs=1 rt=2 imm=0xFFFE -> 0x1022FFFE (macro off). With ENC_BRANCH_REL_EN and wr_ptr=2, imm=0 -> 0x1022FFFD. J target=0x10 -> 0x08000010.
- op_sel=7 with in_valid -> err_illegal pulse 1 cycle, imem_we stays 0, instr_count unchanged; next legal op is written at the same address.
- DEPTH=4: four legal ops -> full=1, in_ready=0; fifth in_valid produces no write. start -> full=0, instr_count=0, next write at addr 0.
- rst_n low during WRITE -> imem_we=0 immediately, all outputs at reset values; after release, first write goes to addr 0.
